// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the CPU (m0) and a debug/DMA master (m1), round-robin with m1 burst lock.
// Define ARB_M0_PRIORITY_EN to give m0 fixed priority instead (m1_lock_i ignored).
module data_ram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              stallreq_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic              m1_lock_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_owner;
    logic [CNT_W-1:0] beat_cnt;
    logic             done0;
    logic             done1;
    logic             burst_ok;

    assign done0      = (state == OWN0) && m0_req_i;
    assign done1      = (state == OWN1) && m1_req_i;
    assign burst_ok   = beat_cnt < BURST_LAST;
    assign m0_ack_o   = done0;
    assign m1_ack_o   = done1;
    assign stallreq_o = m0_req_i & ~done0;

    // A withdrawn request leaves the RAM idle even though the state still names an owner.
    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = '0;
        ram_data_o = '0;
        m0_data_o  = '0;
        m1_data_o  = '0;
        if (done0) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = m0_we_i;
            ram_addr_o = m0_addr_i;
            ram_sel_o  = m0_sel_i;
            ram_data_o = m0_data_i;
            m0_data_o  = ram_data_i;
        end else if (done1) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = m1_we_i;
            ram_addr_o = m1_addr_i;
            ram_sel_o  = m1_sel_i;
            ram_data_o = m1_data_i;
            m1_data_o  = ram_data_i;
        end
    end

`ifdef ARB_M0_PRIORITY_EN
    always_comb begin
        state_nxt = IDLE;
        if (m0_req_i)
            state_nxt = OWN0;
        else if (m1_req_i)
            state_nxt = OWN1;
    end
`else
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (m0_req_i && m1_req_i)
                    state_nxt = last_owner ? OWN0 : OWN1;
                else if (m0_req_i)
                    state_nxt = OWN0;
                else if (m1_req_i)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (m1_req_i)
                    state_nxt = OWN1;
                else if (m0_req_i)
                    state_nxt = OWN0;
            end
            OWN1: begin
                // The lock holds off m0 only until the burst budget is spent.
                if (m1_req_i && m1_lock_i && burst_ok)
                    state_nxt = OWN1;
                else if (m0_req_i)
                    state_nxt = OWN0;
                else if (m1_req_i)
                    state_nxt = OWN1;
            end
            default: state_nxt = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (done0)
                last_owner <= 1'b0;
            else if (done1)
                last_owner <= 1'b1;
            if (state_nxt != OWN1 || !m1_lock_i)
                beat_cnt <= '0;
            else if (done1 && beat_cnt != '1)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter: directed stimulus pushes expected ack order and read data; a negedge monitor checks them.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdat = 0, m1_addr = 0, m1_wdat = 0;
    logic [3:0]  m0_sel = 0, m1_sel = 0;
    logic [31:0] m0_rdat, m1_rdat, ram_addr, ram_wdat, ram_rdat;
    logic        m0_ack, m1_ack, stallreq, ram_ce, ram_we;
    logic [3:0]  ram_sel;

    logic [31:0] mem [16];
    int          checks = 0;
    int          errors = 0;
    logic        qo [$];
    logic [31:0] q0d [$];
    logic [31:0] q1d [$];
    logic        exp_id;

    always #5 clk = ~clk;

    data_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
        .m0_data_i(m0_wdat), .m0_data_o(m0_rdat), .m0_ack_o(m0_ack), .stallreq_o(stallreq),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
        .m1_data_i(m1_wdat), .m1_lock_i(m1_lock), .m1_data_o(m1_rdat), .m1_ack_o(m1_ack),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
        .ram_data_o(ram_wdat), .ram_data_i(ram_rdat)
    );

    assign ram_rdat = mem[ram_addr[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
        end else if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_wdat[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack pops the expected owner and that owner's expected read data.
    always @(negedge clk) begin
        if (!rst && (m0_ack || m1_ack)) begin
            chk("single_ack", {31'b0, m0_ack & m1_ack}, 32'h0);
            if (qo.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack m0_ack=%0b m1_ack=%0b expected no ack at %0t", m0_ack, m1_ack, $time);
            end else begin
                exp_id = qo.pop_front();
                chk("ack_owner", {31'b0, m1_ack}, {31'b0, exp_id});
                if (m0_ack) begin
                    chk("m0_data", m0_rdat, (q0d.size() > 0) ? q0d.pop_front() : 32'hxxxxxxxx);
                    chk("m1_data_nonowner", m1_rdat, 32'h0);
                end else begin
                    chk("m1_data", m1_rdat, (q1d.size() > 0) ? q1d.pop_front() : 32'hxxxxxxxx);
                    chk("m0_data_nonowner", m0_rdat, 32'h0);
                end
            end
        end
    end

    task automatic m0_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [31:0] exp);
        bit got = 0;
        m0_req = 1; m0_we = we; m0_addr = addr; m0_sel = 4'hF; m0_wdat = wdat;
        q0d.push_back(exp);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (m0_ack) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL m0_timeout addr=%h no ack within 20 cycles", addr);
        end
        step();
    endtask

    task automatic m1_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [31:0] exp);
        bit got = 0;
        m1_req = 1; m1_we = we; m1_addr = addr; m1_sel = 4'hF; m1_wdat = wdat;
        q1d.push_back(exp);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (m1_ack) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL m1_timeout addr=%h no ack within 20 cycles", addr);
        end
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both masters requesting: outputs must stay quiet.
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdat = 32'hA5A5A5A5;
        m1_req = 1; m1_we = 1; m1_addr = 32'h14; m1_sel = 4'hF; m1_wdat = 32'h5A5A5A5A;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ram_ce", {31'b0, ram_ce}, 32'h0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_sel", {28'b0, ram_sel}, 32'h0);
        chk("rst_ram_data", ram_wdat, 32'h0);
        chk("rst_acks", {30'b0, m0_ack, m1_ack}, 32'h0);
        chk("rst_rdata", m0_rdat | m1_rdat, 32'h0);
        chk("rst_stallreq", {31'b0, stallreq}, 32'h1);
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        @(posedge clk);
        mem_init = 0;
        @(negedge clk);
        rst = 0;
        step();

        // Simultaneous writes from IDLE: m0 first after reset, m1 the next cycle.
        qo.push_back(1'b0); qo.push_back(1'b1);
        fork
            begin m0_xfer(1, 32'h0, 32'h11111111, 32'h0); m0_req = 0; end
            begin m1_xfer(1, 32'h4, 32'h22222222, 32'h0); m1_req = 0; end
        join
        idle(2);
        qo.push_back(1'b0); qo.push_back(1'b1);
        m0_xfer(0, 32'h0, 32'h0, 32'h11111111); m0_req = 0;
        idle(2);
        m1_xfer(0, 32'h4, 32'h0, 32'h22222222); m1_req = 0;
        idle(2);

        // CPU-only read: one wait cycle with stall, then ack.
        qo.push_back(1'b0); q0d.push_back(32'hDEADBEEF);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_sel = 4'hF;
        @(negedge clk);
        chk("rd_wait_stall", {31'b0, stallreq}, 32'h1);
        chk("rd_wait_ack", {31'b0, m0_ack}, 32'h0);
        @(negedge clk);
        chk("rd_ack", {31'b0, m0_ack}, 32'h1);
        chk("rd_ack_stall", {31'b0, stallreq}, 32'h0);
        step();
        m0_req = 0;
        idle(2);

        // Withdrawal: m1 granted, drops before ack; the next cycle must be IDLE.
        m1_req = 1; m1_we = 0; m1_addr = 32'h4; m1_sel = 4'hF;
        @(negedge clk);
        chk("wd_wait_ack", {31'b0, m1_ack}, 32'h0);
        step();
        m1_req = 0;
        @(negedge clk);
        chk("wd_ram_ce", {31'b0, ram_ce}, 32'h0);
        chk("wd_ack", {31'b0, m1_ack}, 32'h0);
        step();
        m1_req = 1;
        @(negedge clk);
        chk("wd_idle_after", {31'b0, m1_ack}, 32'h0);
        qo.push_back(1'b1); q1d.push_back(32'h22222222);
        step();
        @(negedge clk);
        step();
        m1_req = 0;
        idle(2);

        // Locked m1 burst of 6 beats against a continuously requesting m0.
`ifdef ARB_M0_PRIORITY_EN
        qo.push_back(1'b1); qo.push_back(1'b0); qo.push_back(1'b0);
        for (int i = 0; i < 5; i++) qo.push_back(1'b1);
`else
        for (int i = 0; i < 4; i++) qo.push_back(1'b1);
        qo.push_back(1'b0); qo.push_back(1'b1); qo.push_back(1'b1); qo.push_back(1'b0);
`endif
        fork
            begin
                m1_lock = 1;
                for (int i = 0; i < 6; i++) m1_xfer(1, 32'h20 + 32'(4 * i), 32'h100 + 32'(i), 32'h0);
                m1_req = 0; m1_lock = 0;
            end
            begin
                step();
                m0_xfer(0, 32'h10, 32'h0, 32'hDEADBEEF);
                m0_xfer(0, 32'h0, 32'h0, 32'h11111111);
                m0_req = 0;
            end
        join
        idle(3);
        chk("burst_written", mem[13], 32'h105);

        // Reset asserted between edges during the second locked m1 beat.
        qo.push_back(1'b1); qo.push_back(1'b1);
        q1d.push_back(32'hDEADBEEF); q1d.push_back(32'hDEADBEEF);
        m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 32'h10;
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_ram_ce", {31'b0, ram_ce}, 32'h0);
        chk("arst_acks", {30'b0, m0_ack, m1_ack}, 32'h0);
        chk("arst_m1_data", m1_rdat, 32'h0);
        m1_req = 0; m1_lock = 0;
        idle(2);
        @(negedge clk);
        rst = 0;
        step();
        qo.push_back(1'b0); qo.push_back(1'b1);
        fork
            begin m0_xfer(0, 32'h4, 32'h0, 32'h22222222); m0_req = 0; end
            begin m1_xfer(0, 32'h0, 32'h0, 32'h11111111); m1_req = 0; end
        join
        idle(3);

        chk("order_queue_empty", 32'(qo.size()), 32'h0);
        chk("data_queues_empty", 32'(q0d.size() + q1d.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port data RAM between two masters.
  - m0: CPU load/store port.
  - m1: secondary port (debug loader / DMA).
- Sits between the CPU ram_* port, the m1 master and data_ram; drives data_ram ce/we/addr/sel/data.
- Round-robin arbitration with an optional m1 burst lock; asserts a stall request to the CPU pipeline while m0 waits.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, max consecutive beats m1 may hold the RAM under lock (≥1).
- CNT_W, 2, beat-counter width; must satisfy 2^CNT_W ≥ MAX_BURST.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req_i  in  1  CPU access request (= CPU ram_ce_o).
- m0_we_i  in  1  CPU write enable.
- m0_addr_i  in  ADDR_W  CPU address.
- m0_sel_i  in  4  CPU byte select.
- m0_data_i  in  DATA_W  CPU write data.
- m0_data_o  out  DATA_W  read data to CPU.
- m0_ack_o  out  1  CPU transfer completes this cycle.
- stallreq_o  out  1  = m0_req_i & ~m0_ack_o; feeds CPU ctrl stall.
- m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i: same as m0_* for m1.
- m1_lock_i  in  1  m1 requests to keep ownership for the next beat.
- m1_data_o  out  DATA_W  read data to m1.
- m1_ack_o  out  1  m1 transfer completes this cycle.
- ram_ce_o, ram_we_o  out  1  to data_ram.
- ram_addr_o  out  ADDR_W  to data_ram.
- ram_sel_o  out  4  to data_ram.
- ram_data_o  out  DATA_W  to data_ram.
- ram_data_i  in  DATA_W  from data_ram (combinational read).

Behaviour:
- Reset (async, immediate): state=IDLE, last_owner=1, beat_cnt=0. All RAM outputs, acks and m*_data_o = 0.
- FSM states:
  - IDLE: no RAM access.
  - OWN0: RAM muxed to m0.
  - OWN1: RAM muxed to m1.
- RAM mux and acks are combinational from state and the owner's req.
- In OWNx with req_x=1:
  - ram_ce_o=1; ram_we/addr/sel/data from mx.
  - ack_x=1; mx_data_o=ram_data_i.
  - The write commits at the closing edge.
- In OWNx with req_x=0 (withdrawn): ram_ce_o=0, no ack; the beat does not count.
- Non-owner ack=0 and data_o=0 at all times.
- Masters hold req/we/addr/sel/data stable until ack. Withdrawal before ack is legal.
- Next state from IDLE:
  - Both req → owner = ~last_owner.
  - One req → that master.
  - None → stay IDLE.
- Next state from OWN0:
  - m1_req → OWN1.
  - else m0_req → OWN0.
  - else IDLE.
- Next state from OWN1:
  - m1_req & m1_lock & beat_cnt<MAX_BURST-1 → OWN1 (lock overrides m0).
  - else m0_req → OWN0.
  - else m1_req → OWN1.
  - else IDLE.
- last_owner updates to x on every completed beat in OWNx.
- beat_cnt:
  - +1 on each completed m1 beat while staying in OWN1.
  - Cleared on entering any state other than OWN1, or when m1_lock=0.
  - Saturates; no wrap.
- Latency:
  - Request from IDLE → ack next cycle (1 wait cycle).
  - An owner alone gets back-to-back single-cycle beats.
  - Under contention, beats alternate m0/m1.
- Simultaneous first request after reset: m0 wins (last_owner=1).
- Starvation bound:
  - m0 waits at most MAX_BURST cycles.
  - m1 waits at most 1 cycle after an m0 beat.

Optional Feature:
- Macro: ARB_M0_PRIORITY_EN.
- Defined:
  - m0 has fixed priority; any m0_req preempts m1 at the next state decision, m1_lock ignored.
  - From OWN0, the next state is OWN0 while m0_req, else OWN1 if m1_req, else IDLE.
  - m0 waits at most 1 cycle.
- Undefined: round-robin/lock behaviour above.

Test Plan:
- CPU-only read: m0_req=1, we=0, addr=0x10, RAM holds 0xDEADBEEF → cycle1 stallreq=1 no ack; cycle2 m0_ack=1, m0_data_o=0xDEADBEEF, stallreq=0.
- Simultaneous from IDLE: m0 write 0x11111111@0x0, m1 write 0x22222222@0x4, both held → acks m0,m1 in consecutive cycles; RAM reads back both values.
- m1 locked burst: m1_req=m1_lock=1 for 6 beats, m0_req=1 throughout (MAX_BURST=4) → exactly 4 consecutive m1_acks, then one m0_ack, then m1 resumes.
- Withdrawal: m1 granted, drops req in OWN1 before ack → ram_ce_o=0, no ack, beat_cnt unchanged; next cycle IDLE.
- Reset mid-burst: assert rst during 2nd m1 beat, asynchronously between edges → ram_ce_o and acks 0 immediately; after release, a simultaneous request grants m0 first.
- With ARB_M0_PRIORITY_EN: m1 locked burst, m0_req asserted → m0_ack within 2 cycles; m1 acks only while m0_req=0.
